register_file_loader: RTL and testbench
=======================================

// Module: register_file_loader
// PURPOSE
//  Initiator for the RegisterFile write/read port. Sequences a block load into the register file.
//  - Accepts a stream of words over a valid/ready interface.
//  - Writes each word to consecutive registers FirstReg..LastReg.
//  - Reads every loaded register back through Src1 and checks it against a local shadow copy.
//  - Used by boot/debug logic to preset and self-check the register file.
// PARAMETERS
//  DataWidth   16  width of DIn/SRC1 and stream data
//  SelectSize  3   register select width; register count = 2**SelectSize
// PORTS
//  Clk       in   1           single clock; all state changes on rising edge
//  Reset_N   in   1           asynchronous, active-low reset
//  Start     in   1           begin a load/verify run; sampled only in IDLE
//  FirstReg  in   SelectSize  first destination register; latched on accepted Start
//  LastReg   in   SelectSize  last destination register, inclusive; latched on accepted Start
//  In_Valid  in   1           stream word present
//  In_Data   in   DataWidth   stream word
//  In_Ready  out  1           loader accepts a word this cycle
//  Busy      out  1           run in progress (LOAD, VERIFY or DONE)
//  Done      out  1           one-cycle pulse at end of run
//  Error     out  1           sticky mismatch/illegal-range flag; cleared on next accepted Start
//  ErrReg    out  SelectSize  index of the first mismatching register
//  ErrData   out  DataWidth   value read from ErrReg at the first mismatch
//  REG_WE    out  1           register file write enable, active low
//  DIn       out  DataWidth   register file write data
//  REG_Dst   out  SelectSize  register file write select
//  REG_Src1  out  SelectSize  register file read select 1
//  REG_Src2  out  SelectSize  register file read select 2; constant 0
//  SRC1      in   DataWidth   register file read data 1; combinational from REG_Src1
// BEHAVIOUR
//  - Reset (asynchronous, immediate):
//    - state=IDLE, REG_WE=1, In_Ready=0, Busy=0, Done=0, Error=0.
//    - ErrReg=0, ErrData=0, DIn=0, REG_Dst=0, REG_Src1=0, pointer=0.
//    - Shadow contents need no reset.
//  - Reset during LOAD or VERIFY aborts the run. Registers already written keep their values.
//  - Register file timing: writes on the rising edge while REG_WE=0; reads are combinational.
//  - IDLE:
//    - Start=1 with FirstReg<=LastReg: latch the range, ptr=FirstReg, clear Error/ErrReg/ErrData, go to LOAD.
//    - Start=1 with FirstReg>LastReg: no writes; Error=1, ErrReg=FirstReg, ErrData=0; go to DONE.
//  - LOAD:
//    - In_Ready=1. REG_WE = ~In_Valid (combinational). DIn=In_Data, REG_Dst=ptr.
//    - Accepted beat (In_Valid & In_Ready): the register file and shadow[ptr] capture In_Data at the same edge.
//    - If ptr==LastReg: ptr=FirstReg, go to VERIFY. Otherwise ptr+1.
//    - In_Valid=0 stalls indefinitely with REG_WE=1.
//  - VERIFY:
//    - In_Ready=0, REG_WE=1. One register per cycle; REG_Src1=ptr.
//    - At each edge compare SRC1 to shadow[ptr]. The first mismatch sets Error and captures ErrReg=ptr, ErrData=SRC1.
//    - Later mismatches change nothing. The run always continues to LastReg.
//    - At ptr==LastReg go to DONE.
//  - DONE: Done=1 for exactly one cycle, then IDLE. Busy=1 in LOAD/VERIFY/DONE.
//  - Start while Busy is ignored.
//  - Latency: N=LastReg-FirstReg+1. With no stalls, LOAD takes N cycles and VERIFY N cycles.
//    - Done is high in cycle 2N+1 after the Start edge.
//  - Boundaries:
//    - ptr never wraps; LastReg=2**SelectSize-1 is legal. FirstReg==LastReg is a single-register run.
//    - Shadow array write and read are in different states, so there are no simultaneous collisions.
// STRUCTURE
//  - Shared header regfile_defs.vh holds:
//    - state localparams IDLE/LOAD/VERIFY/DONE (2-bit);
//    - REG_WE_ENABLE=1'b0, REG_WE_DISABLE=1'b1.
//  - One sub-module, regfile_shadow: 2**SelectSize x DataWidth flops, synchronous write, combinational read.
//  - FSM, pointer and error capture stay in the top module.
// TESTING (bench instantiates RegisterFile as the responder)
//  1. Reset, then Start with range 0..0 and In_Data=0x00A0:
//     REG_WE low for exactly one cycle and SRC1 reads 0x00A0. Done pulses; Error=0.
//  2. Range 1..3, words 0x000A,0x000B,0x000C, no stalls:
//     registers 1..3 hold those words. Done arrives 7 cycles after Start; Busy is high throughout.
//  3. Range 2..4 with In_Valid low on alternate cycles:
//     REG_WE high during every stall. Values land in the correct registers and Done follows.
//  4. Force a corruption (bench overwrites reg 5 with 0xFFFF during VERIFY of 4..6, data 0x1234):
//     Error=1, ErrReg=5, ErrData=0xFFFF. Done still pulses.
//  5. Start with FirstReg=6, LastReg=2: no REG_WE pulse; Error=1, ErrReg=6; Done pulses next cycle.
//  6. Assert Reset_N low mid-LOAD of 0..7 after 3 beats:
//     REG_WE=1 immediately and state=IDLE. A new Start clears Error and completes normally.

Source files
------------

// File: rtl/register_file_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : register_file_loader_pkg
// Purpose  : Shared types and constants for the register file loader.
//            Holds the loader state encoding, the register-file write-enable
//            polarity and the default bus widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package register_file_loader_pkg;

    // Loader sequencing states (2-bit encoding).
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_VERIFY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // The register file write enable is active low.
    localparam logic REG_WE_ENABLE  = 1'b0;
    localparam logic REG_WE_DISABLE = 1'b1;

    // Default geometry: 16-bit registers, 8 of them.
    localparam int DEFAULT_DATA_WIDTH  = 16;
    localparam int DEFAULT_SELECT_SIZE = 3;

endpackage : register_file_loader_pkg
`default_nettype wire

// File: rtl/register_file_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : register_file_loader_if
// Purpose  : Bundles every non-clock signal of the loader: run control,
//            word stream handshake, status/error reporting and the register
//            file write/read port.
// Modports : master - the loader (drives stream ready, status, RF controls)
//            slave  - its environment (host + register file)
// Revision : 1.0 - initial release
// ============================================================================
interface register_file_loader_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int SELECT_SIZE = 3
);
    // Run control
    logic                   start;
    logic [SELECT_SIZE-1:0] first_reg;
    logic [SELECT_SIZE-1:0] last_reg;
    // Word stream
    logic                   in_valid;
    logic [DATA_WIDTH-1:0]  in_data;
    logic                   in_ready;
    // Status
    logic                   busy;
    logic                   done;
    logic                   error;
    logic [SELECT_SIZE-1:0] err_reg;
    logic [DATA_WIDTH-1:0]  err_data;
    // Register file port
    logic                   reg_we;
    logic [DATA_WIDTH-1:0]  din;
    logic [SELECT_SIZE-1:0] reg_dst;
    logic [SELECT_SIZE-1:0] reg_src1;
    logic [SELECT_SIZE-1:0] reg_src2;
    logic [DATA_WIDTH-1:0]  src1;

    modport master (
        input  start, first_reg, last_reg, in_valid, in_data, src1,
        output in_ready, busy, done, error, err_reg, err_data,
               reg_we, din, reg_dst, reg_src1, reg_src2
    );

    modport slave (
        output start, first_reg, last_reg, in_valid, in_data, src1,
        input  in_ready, busy, done, error, err_reg, err_data,
               reg_we, din, reg_dst, reg_src1, reg_src2
    );

endinterface : register_file_loader_if
`default_nettype wire

// File: rtl/register_file_loader_shadow.sv
`default_nettype none
// ============================================================================
// Module   : register_file_loader_shadow
// Purpose  : Local shadow copy of the register file. 2**SELECT_SIZE words of
//            DATA_WIDTH flops, synchronous write, combinational read.
//            Contents are not reset; only words written in the current run
//            are ever compared.
// Ports    : clk      - clock
//            wr_en    - write strobe (active high)
//            wr_addr  - write index
//            wr_data  - write data
//            rd_addr  - read index
//            rd_data  - combinational read data
// Revision : 1.0 - initial release
// ============================================================================
module register_file_loader_shadow #(
    parameter int DATA_WIDTH  = 16,
    parameter int SELECT_SIZE = 3
) (
    input  wire logic                   clk,
    input  wire logic                   wr_en,
    input  wire logic [SELECT_SIZE-1:0] wr_addr,
    input  wire logic [DATA_WIDTH-1:0]  wr_data,
    input  wire logic [SELECT_SIZE-1:0] rd_addr,
    output logic      [DATA_WIDTH-1:0]  rd_data
);

    localparam int DEPTH = 2 ** SELECT_SIZE;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule : register_file_loader_shadow
`default_nettype wire

// File: rtl/register_file_loader.sv
`default_nettype none
// ============================================================================
// Module   : register_file_loader
// Purpose  : Block-load initiator for a register file. Accepts a word stream,
//            writes it to registers first_reg..last_reg, then reads each one
//            back through src1 and compares it with a local shadow copy.
//            The first mismatch (or an inverted range) raises a sticky error.
// Ports    : clk    - single clock, rising edge
//            rst_n  - asynchronous active-low reset
//            bus    - register_file_loader_if.master:
//                     start/first_reg/last_reg   run request
//                     in_valid/in_data/in_ready  word stream
//                     busy/done/error/err_reg/err_data status
//                     reg_we/din/reg_dst/reg_src1/reg_src2/src1 RF port
// Revision : 1.0 - initial release
// ============================================================================
module register_file_loader
    import register_file_loader_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SELECT_SIZE = DEFAULT_SELECT_SIZE
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    register_file_loader_if.master  bus
);

    state_t                 state;
    logic [SELECT_SIZE-1:0] ptr;
    logic [SELECT_SIZE-1:0] first_q;
    logic [SELECT_SIZE-1:0] last_q;
    logic                   in_ready_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   error_q;
    logic [SELECT_SIZE-1:0] err_reg_q;
    logic [DATA_WIDTH-1:0]  err_data_q;

    logic                   accept;
    logic [DATA_WIDTH-1:0]  shadow_rdata;

    // A beat is accepted whenever the loader is in LOAD and a word is offered.
    assign accept = in_ready_q & bus.in_valid;

    // Shadow write and read never coincide: writes happen only in LOAD,
    // comparisons only in VERIFY, so one pointer serves both ports.
    register_file_loader_shadow #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SELECT_SIZE (SELECT_SIZE)
    ) u_shadow (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (ptr),
        .wr_data (bus.in_data),
        .rd_addr (ptr),
        .rd_data (shadow_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            first_q    <= '0;
            last_q     <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_reg_q  <= '0;
            err_data_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.first_reg <= bus.last_reg) begin
                            first_q    <= bus.first_reg;
                            last_q     <= bus.last_reg;
                            ptr        <= bus.first_reg;
                            error_q    <= 1'b0;
                            err_reg_q  <= '0;
                            err_data_q <= '0;
                            in_ready_q <= 1'b1;
                            state      <= ST_LOAD;
                        end else begin
                            // Inverted range: report it and finish without writing.
                            error_q    <= 1'b1;
                            err_reg_q  <= bus.first_reg;
                            err_data_q <= '0;
                            done_q     <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end
                end

                ST_LOAD: begin
                    if (accept) begin
                        if (ptr == last_q) begin
                            ptr        <= first_q;
                            in_ready_q <= 1'b0;
                            state      <= ST_VERIFY;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end
                end

                ST_VERIFY: begin
                    // Only the first mismatch of a run is captured.
                    if ((bus.src1 != shadow_rdata) && !error_q) begin
                        error_q    <= 1'b1;
                        err_reg_q  <= ptr;
                        err_data_q <= bus.src1;
                    end
                    if (ptr == last_q) begin
                        done_q <= 1'b1;
                        state  <= ST_DONE;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end

                ST_DONE: begin
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // The write enable follows in_valid in the same cycle so a stalled
    // stream never produces a spurious register write.
    assign bus.reg_we   = ((state == ST_LOAD) && bus.in_valid) ? REG_WE_ENABLE
                                                               : REG_WE_DISABLE;
    assign bus.din      = (state == ST_LOAD) ? bus.in_data : '0;
    assign bus.reg_dst  = ptr;
    assign bus.reg_src1 = ptr;
    assign bus.reg_src2 = '0;

    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.error    = error_q;
    assign bus.err_reg  = err_reg_q;
    assign bus.err_data = err_data_q;

endmodule : register_file_loader
`default_nettype wire

// File: tb/tb_register_file_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file_loader
// Purpose  : Self-checking bench for register_file_loader. Provides the
//            register file responder, a write scoreboard and directed runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file_loader;

    localparam int DW   = 16;
    localparam int SS   = 3;
    localparam int NREG = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    register_file_loader_if #(.DATA_WIDTH(DW), .SELECT_SIZE(SS)) bus ();

    register_file_loader #(.DATA_WIDTH(DW), .SELECT_SIZE(SS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- register file responder ----------------
    logic [DW-1:0] rf [NREG];
    logic          corrupt_req = 1'b0;
    logic [SS-1:0] corrupt_idx = '0;
    logic [DW-1:0] corrupt_val = '0;

    always @(posedge clk) begin
        if (bus.reg_we == 1'b0) rf[bus.reg_dst] <= bus.din;
        if (corrupt_req)        rf[corrupt_idx] <= corrupt_val;
    end

    assign bus.src1 = rf[bus.reg_src1];

    // ---------------- checking ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- write scoreboard ----------------
    typedef struct packed {
        logic [SS-1:0] dst;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  we_cycles  = 0;
    int  stall_seen = 0;
    int  stall_bad  = 0;

    always @(negedge clk) begin
        if (rst_n && bus.reg_we == 1'b0) begin
            we_cycles++;
            if (exp_q.size() == 0) begin
                check_val("unexpected_write", 32'(bus.reg_dst), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("write_dst",  32'(bus.reg_dst), 32'(mon_e.dst));
                check_val("write_data", 32'(bus.din),     32'(mon_e.data));
            end
        end
        if (rst_n && bus.in_ready && !bus.in_valid) begin
            stall_seen++;
            if (bus.reg_we !== 1'b1) stall_bad++;
        end
    end

    logic [DW-1:0] model [NREG];

    // One complete run: Start, feed words (optionally with a bubble after
    // each beat), wait for Done and check status, latency and contents.
    task automatic do_run(input int f, input int l, input logic [DW-1:0] words[$],
                          input bit stall, input bit corrupt,
                          input bit exp_err, input int exp_err_reg,
                          input logic [DW-1:0] exp_err_data, input int exp_cycles);
        int n;
        int cyc;
        int we0;
        int st0;
        int bad0;
        bit got_done;
        bit busy_ok;
        n        = (f <= l) ? (l - f + 1) : 0;
        cyc      = 0;
        got_done = 1'b0;
        busy_ok  = 1'b1;
        we0      = we_cycles;
        st0      = stall_seen;
        bad0     = stall_bad;
        for (int i = 0; i < n; i++) model[f + i] = words[i];
        if (corrupt) model[corrupt_idx] = corrupt_val;

        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.first_reg = SS'(f);
        bus.last_reg  = SS'(l);
        @(posedge clk); #1;
        bus.start = 1'b0;

        fork
            begin : feeder
                for (int i = 0; i < n; i++) begin
                    bit acc;
                    int g;
                    g = 0;
                    exp_q.push_back('{dst: SS'(f + i), data: words[i]});
                    bus.in_valid = 1'b1;
                    bus.in_data  = words[i];
                    forever begin
                        @(negedge clk);
                        acc = bus.in_ready;
                        @(posedge clk); #1;
                        if (acc) break;
                        g++;
                        if (g > 50) begin
                            check_val("feed_timeout", 32'(g), 32'd0);
                            i = n;
                            break;
                        end
                    end
                    bus.in_valid = 1'b0;
                    if (stall && i < n - 1) begin
                        @(posedge clk); #1;
                    end
                end
                bus.in_valid = 1'b0;
            end
            begin : watcher
                while (!got_done && cyc < 200) begin
                    @(negedge clk);
                    cyc++;
                    corrupt_req = corrupt && (cyc == n + 1);
                    if (bus.done) got_done = 1'b1;
                    else if (!bus.busy) busy_ok = 1'b0;
                end
                corrupt_req = 1'b0;
            end
        join

        check_val("done_seen", 32'(got_done), 32'd1);
        if (exp_cycles >= 0) check_val("done_latency", 32'(cyc), 32'(exp_cycles));
        check_val("busy_during_run", 32'(busy_ok),      32'd1);
        check_val("error",           32'(bus.error),    32'(exp_err));
        check_val("err_reg",         32'(bus.err_reg),  32'(exp_err_reg));
        check_val("err_data",        32'(bus.err_data), 32'(exp_err_data));
        @(negedge clk);
        check_val("done_one_cycle",  32'(bus.done), 32'd0);
        check_val("busy_after_done", 32'(bus.busy), 32'd0);
        check_val("write_count",     32'(we_cycles - we0), 32'(n));
        check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        if (stall) begin
            check_val("stalls_seen",     32'(stall_seen - st0 > 0), 32'd1);
            check_val("stall_we_high",   32'(stall_bad - bad0),     32'd0);
        end
        for (int i = 0; i < n; i++)
            check_val($sformatf("rf_content_%0d", f + i), 32'(rf[f + i]), 32'(model[f + i]));
    endtask

    initial begin
        logic [DW-1:0] w[$];
        bus.start     = 1'b0;
        bus.first_reg = '0;
        bus.last_reg  = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;

        // Reset state
        #12;
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_val("rst_busy",     32'(bus.busy),     32'd0);
        check_val("rst_done",     32'(bus.done),     32'd0);
        check_val("rst_error",    32'(bus.error),    32'd0);
        check_val("rst_err_reg",  32'(bus.err_reg),  32'd0);
        check_val("rst_err_data", 32'(bus.err_data), 32'd0);
        check_val("rst_reg_we",   32'(bus.reg_we),   32'd1);
        check_val("rst_din",      32'(bus.din),      32'd0);
        check_val("rst_reg_dst",  32'(bus.reg_dst),  32'd0);
        check_val("rst_reg_src1", 32'(bus.reg_src1), 32'd0);
        check_val("rst_reg_src2", 32'(bus.reg_src2), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1. single-register run
        w = '{16'h00A0};
        do_run(0, 0, w, 1'b0, 1'b0, 1'b0, 0, 16'h0000, 3);

        // 2. range 1..3, no stalls: Done 7 cycles after Start
        w = '{16'h000A, 16'h000B, 16'h000C};
        do_run(1, 3, w, 1'b0, 1'b0, 1'b0, 0, 16'h0000, 7);

        // 3. range 2..4 with a bubble after every beat
        w = '{16'h1111, 16'h2222, 16'h3333};
        do_run(2, 4, w, 1'b1, 1'b0, 1'b0, 0, 16'h0000, -1);

        // 4. corruption of reg 5 during verify of 4..6
        corrupt_idx = 3'd5;
        corrupt_val = 16'hFFFF;
        w = '{16'h1234, 16'h1234, 16'h1234};
        do_run(4, 6, w, 1'b0, 1'b1, 1'b1, 5, 16'hFFFF, 7);

        // 5. inverted range: no writes, error on FirstReg, Done next cycle
        w = {};
        do_run(6, 2, w, 1'b0, 1'b0, 1'b1, 6, 16'h0000, 1);

        // 6. reset mid-load of 0..7 after 3 beats
        w = '{16'hA000, 16'hA001, 16'hA002, 16'hA003,
              16'hA004, 16'hA005, 16'hA006, 16'hA007};
        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.first_reg = 3'd0;
        bus.last_reg  = 3'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{dst: SS'(i), data: w[i]});
            bus.in_valid = 1'b1;
            bus.in_data  = w[i];
            @(posedge clk); #1;
        end
        bus.in_data = w[3];
        #1;
        check_val("we_low_before_reset", 32'(bus.reg_we), 32'd0);
        rst_n = 1'b0;
        #1;
        check_val("reset_reg_we",   32'(bus.reg_we),   32'd1);
        check_val("reset_in_ready", 32'(bus.in_ready), 32'd0);
        check_val("reset_busy",     32'(bus.busy),     32'd0);
        check_val("reset_error",    32'(bus.error),    32'd0);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_val("aborted_scoreboard", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 3; i++)
            check_val($sformatf("aborted_rf_%0d", i), 32'(rf[i]), 32'(w[i]));
        do_run(0, 7, w, 1'b0, 1'b0, 1'b0, 0, 16'h0000, 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule : tb_register_file_loader
`default_nettype wire
